// File: rtl/pipe_pkg.sv
// Shared widths and control-bit positions for the EX/MEM pipeline bundles.
package pipe_pkg;

  localparam int unsigned EXMEM_DATA_W = 101;
  localparam int unsigned EXMEM_CTRL_W = 4;

  localparam int unsigned CTRL_MEMWRITE = 0;
  localparam int unsigned CTRL_MEMREAD  = 1;
  localparam int unsigned CTRL_MEMTOREG = 2;
  localparam int unsigned CTRL_REGWRITE = 3;

endpackage

// File: rtl/pipe_stage_cell.sv
// One pipeline stage: valid/ctrl/data with load, hold and kill.
// Kill clears valid and ctrl but keeps data, so an invalid stage never carries live control.
module pipe_stage_cell
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = EXMEM_CTRL_W,
  parameter int unsigned DATA_W = EXMEM_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load,
  input  logic              kill,
  input  logic              nxt_valid,
  input  logic [CTRL_W-1:0] nxt_ctrl,
  input  logic [DATA_W-1:0] nxt_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (kill) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= nxt_valid;
      ctrl  <= nxt_valid ? nxt_ctrl : '0;
      data  <= nxt_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// DEPTH-deep pipeline register with flush, bubble and stall, plus a
// saturating consecutive-stall counter with a registered timeout flag.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W           = EXMEM_DATA_W,
  parameter int unsigned CTRL_W           = EXMEM_CTRL_W,
  parameter int unsigned DEPTH            = 1,
  parameter bit          FLUSH_OVER_STALL = 1'b1,
  parameter int unsigned STALL_CNT_W      = 8,
  parameter int unsigned STALL_TIMEOUT    = 200
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   stall_i,
  input  logic                   flush_i,
  input  logic                   bubble_i,
  input  logic                   valid_i,
  input  logic [CTRL_W-1:0]      ctrl_i,
  input  logic [DATA_W-1:0]      data_i,
  output logic                   valid_o,
  output logic [CTRL_W-1:0]      ctrl_o,
  output logic [DATA_W-1:0]      data_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o,
  output logic                   stall_timeout_o
);

  localparam logic [STALL_CNT_W-1:0] CNT_MAX = '1;

  logic              flush_eff;
  logic              load;
  logic              kill      [DEPTH];
  logic              in_valid  [DEPTH];
  logic [CTRL_W-1:0] in_ctrl   [DEPTH];
  logic [DATA_W-1:0] in_data   [DEPTH];
  logic              stg_valid [DEPTH];
  logic [CTRL_W-1:0] stg_ctrl  [DEPTH];
  logic [DATA_W-1:0] stg_data  [DEPTH];

  assign flush_eff = flush_i & (FLUSH_OVER_STALL | ~stall_i);
  assign load      = ~stall_i;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      // A bubble only kills the head; the rest of the chain still advances.
      assign kill[k]     = flush_eff | (bubble_i & ~stall_i);
      assign in_valid[k] = valid_i;
      assign in_ctrl[k]  = ctrl_i;
      assign in_data[k]  = data_i;
    end else begin : g_body
      assign kill[k]     = flush_eff;
      assign in_valid[k] = stg_valid[k-1];
      assign in_ctrl[k]  = stg_ctrl[k-1];
      assign in_data[k]  = stg_data[k-1];
    end

    pipe_stage_cell #(
      .CTRL_W (CTRL_W),
      .DATA_W (DATA_W)
    ) u_cell (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .load      (load),
      .kill      (kill[k]),
      .nxt_valid (in_valid[k]),
      .nxt_ctrl  (in_ctrl[k]),
      .nxt_data  (in_data[k]),
      .valid     (stg_valid[k]),
      .ctrl      (stg_ctrl[k]),
      .data      (stg_data[k])
    );
  end

  assign valid_o = stg_valid[DEPTH-1];
  assign ctrl_o  = stg_ctrl[DEPTH-1];
  assign data_o  = stg_data[DEPTH-1];

  logic [STALL_CNT_W-1:0] stall_cnt_nxt;
  logic                   timeout_nxt;

  always_comb begin
    stall_cnt_nxt = '0;
    timeout_nxt   = 1'b0;
    if (stall_i) begin
      stall_cnt_nxt = (stall_cnt_o == CNT_MAX) ? stall_cnt_o : stall_cnt_o + 1'b1;
    end
    // Flag tracks the next count so it rises on the same edge the count crosses.
    if (STALL_TIMEOUT != 0) begin
      timeout_nxt = 32'(stall_cnt_nxt) >= 32'(STALL_TIMEOUT);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o     <= '0;
      stall_timeout_o <= 1'b0;
    end else begin
      stall_cnt_o     <= stall_cnt_nxt;
      stall_timeout_o <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: three instances (DEPTH 1, DEPTH 3, DEPTH 2 with narrow
// counter and flush-under-stall disabled) share one stimulus stream.
module tb_pipe_stage_reg;

  logic         clk_i = 1'b0;
  logic         rst_i, stall_i, flush_i, bubble_i, valid_i;
  logic [3:0]   ctrl_i;
  logic [100:0] data_i;

  logic         a_valid, b_valid, c_valid;
  logic [3:0]   a_ctrl, b_ctrl, c_ctrl;
  logic [100:0] a_data, b_data, c_data;
  logic [7:0]   a_cnt, b_cnt;
  logic [3:0]   c_cnt;
  logic         a_to, b_to, c_to;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  pipe_stage_reg #(.DEPTH(1)) u_a (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .bubble_i(bubble_i), .valid_i(valid_i), .ctrl_i(ctrl_i), .data_i(data_i),
    .valid_o(a_valid), .ctrl_o(a_ctrl), .data_o(a_data),
    .stall_cnt_o(a_cnt), .stall_timeout_o(a_to)
  );

  pipe_stage_reg #(.DEPTH(3)) u_b (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .bubble_i(bubble_i), .valid_i(valid_i), .ctrl_i(ctrl_i), .data_i(data_i),
    .valid_o(b_valid), .ctrl_o(b_ctrl), .data_o(b_data),
    .stall_cnt_o(b_cnt), .stall_timeout_o(b_to)
  );

  pipe_stage_reg #(.DEPTH(2), .FLUSH_OVER_STALL(1'b0), .STALL_CNT_W(4), .STALL_TIMEOUT(10)) u_c (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .bubble_i(bubble_i), .valid_i(valid_i), .ctrl_i(ctrl_i), .data_i(data_i),
    .valid_o(c_valid), .ctrl_o(c_ctrl), .data_o(c_data),
    .stall_cnt_o(c_cnt), .stall_timeout_o(c_to)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0; bubble_i = 1'b0;
    valid_i = 1'b1; ctrl_i = 4'b1111; data_i = 101'h7;
    step();
    chk("rst a_valid", a_valid, 0);
    chk("rst a_ctrl", a_ctrl, 0);
    chk("rst a_data", a_data, 0);
    chk("rst b_valid", b_valid, 0);
    chk("rst c_data", c_data, 0);
    chk("rst c_cnt", c_cnt, 0);
    chk("rst c_to", c_to, 0);

    // Stream 1..5 through all instances.
    rst_i = 1'b0; ctrl_i = 4'b1010;
    for (int i = 1; i <= 5; i++) begin
      data_i = 101'(i);
      step();
      chk("stream a_data", a_data, i);
      chk("stream a_valid", a_valid, 1);
      chk("stream a_ctrl", a_ctrl, 4'b1010);
      if (i >= 3) chk("stream b_data", b_data, i - 2);
    end

    // DEPTH=3: load 0xAA then stall 4 cycles; output frozen at 4.
    data_i = 101'hAA;
    step();
    chk("load b_data", b_data, 4);
    stall_i = 1'b1; data_i = 101'hBB;
    for (int n = 1; n <= 4; n++) begin
      step();
      chk("stall b_data", b_data, 4);
      chk("stall b_valid", b_valid, 1);
      chk("stall b_cnt", b_cnt, n);
    end
    stall_i = 1'b0;
    step();
    chk("release b_data", b_data, 5);
    chk("release b_cnt", b_cnt, 0);
    step();
    chk("AA out b_data", b_data, 101'hAA);
    chk("AA out b_ctrl", b_ctrl, 4'b1010);

    // Flush together with stall: honoured on A/B, ignored on C.
    stall_i = 1'b1; flush_i = 1'b1; data_i = 101'hCC;
    step();
    chk("fls a_valid", a_valid, 0);
    chk("fls a_ctrl", a_ctrl, 0);
    chk("fls a_data held", a_data, 101'hBB);
    chk("fls b_valid", b_valid, 0);
    chk("fls c_valid held", c_valid, 1);
    chk("fls c_ctrl held", c_ctrl, 4'b1010);
    chk("fls c_data held", c_data, 101'hBB);
    chk("fls c_cnt", c_cnt, 1);
    stall_i = 1'b0; flush_i = 1'b0;

    // DEPTH=2 bubble: 0x33 emerges, then the bubble.
    data_i = 101'h33;
    step();
    bubble_i = 1'b1; data_i = 101'h55;
    step();
    chk("bub c_data", c_data, 101'h33);
    chk("bub c_valid", c_valid, 1);
    chk("bub c_ctrl", c_ctrl, 4'b1010);
    chk("bub a_valid", a_valid, 0);
    chk("bub a_ctrl", a_ctrl, 0);
    chk("bub a_data held", a_data, 101'h33);
    bubble_i = 1'b0; data_i = 101'h66;
    step();
    chk("bub out c_valid", c_valid, 0);
    chk("bub out c_ctrl", c_ctrl, 0);
    chk("bub a_data", a_data, 101'h66);

    // Long stall: C flags at 10, saturates at 15.
    stall_i = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      step();
      chk("long c_cnt", c_cnt, (n > 15) ? 15 : n);
      chk("long c_to", c_to, (n >= 10) ? 1 : 0);
      chk("long b_to", b_to, 0);
    end
    chk("long b_cnt", b_cnt, 20);
    // Release with an invalid entry carrying nonzero ctrl.
    stall_i = 1'b0; valid_i = 1'b0; ctrl_i = 4'b1111; data_i = 101'h99;
    step();
    chk("clr c_cnt", c_cnt, 0);
    chk("clr c_to", c_to, 0);
    chk("inv a_valid", a_valid, 0);
    chk("inv a_ctrl", a_ctrl, 0);
    chk("inv a_data", a_data, 101'h99);

    // Fill B, stall long enough for C's flag, then reset mid-stall.
    valid_i = 1'b1; ctrl_i = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      data_i = 101'(8'h71 + i);
      step();
    end
    chk("fill b_data", b_data, 101'h71);
    stall_i = 1'b1;
    for (int n = 0; n < 12; n++) step();
    chk("pre b_valid", b_valid, 1);
    chk("pre b_cnt", b_cnt, 12);
    chk("pre c_to", c_to, 1);
    rst_i = 1'b1;
    step();
    chk("rst2 b_valid", b_valid, 0);
    chk("rst2 b_ctrl", b_ctrl, 0);
    chk("rst2 b_data", b_data, 0);
    chk("rst2 b_cnt", b_cnt, 0);
    chk("rst2 a_valid", a_valid, 0);
    chk("rst2 c_valid", c_valid, 0);
    chk("rst2 c_cnt", c_cnt, 0);
    chk("rst2 c_to", c_to, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
